// File: rtl/monitor_pkg.sv
// Shared types and helpers for the debug-monitor selector.
// Holds the FSM state enum, reset constants and packed-bus slice helper.
// No ports; imported by monitor_snapshot and monitor_scanner.
package monitor_pkg;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      SCAN   = 2'd1,
      HOLD   = 2'd2
   } mon_state_t;

   // Reset value of every data bit (replicated to DATA_W at the use site).
   localparam logic MON_RST_DATA = 1'b0;

   // LSB position of channel k inside a packed bus of w-bit channels.
   function automatic int ch_slice(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/monitor_snapshot.sv
// Snapshot bank: CH_NUM x DATA_W registers loaded together on cap_i.
// Ports: clk/rst, cap_i capture strobe, ch_data_i packed channels,
//        rd_idx_i read index, rd_dat_o combinational read (0 if out of range).
module monitor_snapshot
   import monitor_pkg::*;
#(
   parameter int CH_NUM = 8,
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cap_i,
   input  logic [CH_NUM*DATA_W-1:0] ch_data_i,
   input  logic [SEL_W-1:0]         rd_idx_i,
   output logic [DATA_W-1:0]        rd_dat_o
);

   logic [DATA_W-1:0] bank_q [CH_NUM];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < CH_NUM; k++) begin
            bank_q[k] <= {DATA_W{MON_RST_DATA}};
         end
      end else if (cap_i) begin
         for (int k = 0; k < CH_NUM; k++) begin
            bank_q[k] <= ch_data_i[ch_slice(k, DATA_W) +: DATA_W];
         end
      end
   end

   always_comb begin
      rd_dat_o = {DATA_W{MON_RST_DATA}};
      for (int k = 0; k < CH_NUM; k++) begin
         if (rd_idx_i == SEL_W'(k)) begin
            rd_dat_o = bank_q[k];
         end
      end
   end

endmodule

// File: rtl/monitor_scanner.sv
// Debug-monitor selector: shows one of CH_NUM channels on a registered output,
// with auto-scan, freeze/snapshot and a change-detect strobe. 1-cycle latency.
// Ports: clk, rst (async high), ch_data, chose, scan_en, freeze ->
//        mon_data, mon_ch, mon_valid, changed.
// Build option MONITOR_SCAN_EN: when undefined, auto-scan is removed and
// scan_en / SCAN_DIV are ignored (port list unchanged).
module monitor_scanner
   import monitor_pkg::*;
#(
   parameter int CH_NUM   = 8,
   parameter int DATA_W   = 8,
   parameter int SEL_W    = 3,
   parameter int SCAN_DIV = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CH_NUM*DATA_W-1:0] ch_data,
   input  logic [SEL_W-1:0]         chose,
   input  logic                     scan_en,
   input  logic                     freeze,
   output logic [DATA_W-1:0]        mon_data,
   output logic [SEL_W-1:0]         mon_ch,
   output logic                     mon_valid,
   output logic                     changed
);

   mon_state_t        state_q, state_d;
   logic              freeze_q;
   logic              capture;
   logic              scan_go;
   logic [SEL_W-1:0]  rd_idx;
   logic              in_range;
   logic [DATA_W-1:0] live_dat, snap_dat;
   logic [DATA_W-1:0] mon_data_q, mon_data_d;
   logic [SEL_W-1:0]  mon_ch_q, mon_ch_d;
   logic              mon_valid_q, mon_valid_d;
   logic              changed_q, changed_d;

`ifdef MONITOR_SCAN_EN
   localparam int CNT_W = $clog2(SCAN_DIV);

   logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

   assign scan_go = scan_en;

   always_comb begin
      scan_idx_d = scan_idx_q;
      div_cnt_d  = div_cnt_q;
      if (state_d == SCAN && state_q != SCAN) begin
         // every entry into SCAN restarts from channel 0
         scan_idx_d = '0;
         div_cnt_d  = '0;
      end else if (state_q == SCAN) begin
         if (div_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            div_cnt_d  = '0;
            scan_idx_d = (scan_idx_q == SEL_W'(CH_NUM - 1)) ? '0 : scan_idx_q + 1'b1;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_idx_q <= '0;
         div_cnt_q  <= '0;
      end else begin
         scan_idx_q <= scan_idx_d;
         div_cnt_q  <= div_cnt_d;
      end
   end

   assign rd_idx = (state_q == SCAN) ? scan_idx_q : chose;
`else
   logic unused_cfg;
   assign unused_cfg = scan_en ^ (SCAN_DIV == 0);
   assign scan_go    = 1'b0;
   assign rd_idx     = chose;
`endif

   // Freeze rising edge beats everything, including a simultaneous scan_en.
   always_comb begin
      state_d = state_q;
      capture = freeze & ~freeze_q;
      if (capture) begin
         state_d = HOLD;
      end else begin
         case (state_q)
            MANUAL:  if (scan_go)  state_d = SCAN;
            SCAN:    if (!scan_go) state_d = MANUAL;
            HOLD:    if (!freeze)  state_d = scan_go ? SCAN : MANUAL;
            default: state_d = MANUAL;
         endcase
      end
   end

   monitor_snapshot #(
      .CH_NUM (CH_NUM),
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
   ) u_snap (
      .clk       (clk),
      .rst       (rst),
      .cap_i     (capture),
      .ch_data_i (ch_data),
      .rd_idx_i  (rd_idx),
      .rd_dat_o  (snap_dat)
   );

   always_comb begin
      live_dat = {DATA_W{MON_RST_DATA}};
      for (int k = 0; k < CH_NUM; k++) begin
         if (rd_idx == SEL_W'(k)) begin
            live_dat = ch_data[ch_slice(k, DATA_W) +: DATA_W];
         end
      end
   end

   assign in_range = (int'(rd_idx) < CH_NUM);

   always_comb begin
      mon_ch_d    = rd_idx;
      mon_valid_d = in_range;
      mon_data_d  = {DATA_W{MON_RST_DATA}};
      if (in_range) begin
         mon_data_d = (state_q == HOLD) ? snap_dat : live_dat;
      end
      // Previous output must be valid too, which keeps the first cycle after
      // reset quiet; a frozen display is never reported as a change.
      changed_d = mon_valid_q & mon_valid_d & (mon_ch_d == mon_ch_q) &
                  (mon_data_d != mon_data_q) & (state_q != HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= MANUAL;
         freeze_q    <= 1'b0;
         mon_data_q  <= {DATA_W{MON_RST_DATA}};
         mon_ch_q    <= '0;
         mon_valid_q <= 1'b0;
         changed_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         freeze_q    <= freeze;
         mon_data_q  <= mon_data_d;
         mon_ch_q    <= mon_ch_d;
         mon_valid_q <= mon_valid_d;
         changed_q   <= changed_d;
      end
   end

   assign mon_data  = mon_data_q;
   assign mon_ch    = mon_ch_q;
   assign mon_valid = mon_valid_q;
   assign changed   = changed_q;

endmodule

// File: tb/tb_monitor_scanner.sv
module tb_monitor_scanner;

   localparam int CH_NUM   = 8;
   localparam int DATA_W   = 8;
   localparam int SEL_W    = 4;
   localparam int SCAN_DIV = 4;
`ifdef MONITOR_SCAN_EN
   localparam bit SCAN_ON = 1'b1;
`else
   localparam bit SCAN_ON = 1'b0;
`endif

   logic                     clk;
   logic                     rst;
   logic [CH_NUM*DATA_W-1:0] ch_data;
   logic [SEL_W-1:0]         chose;
   logic                     scan_en;
   logic                     freeze;
   logic [DATA_W-1:0]        mon_data;
   logic [SEL_W-1:0]         mon_ch;
   logic                     mon_valid;
   logic                     changed;

   int checks = 0;
   int errors = 0;

   monitor_scanner #(
      .CH_NUM   (CH_NUM),
      .DATA_W   (DATA_W),
      .SEL_W    (SEL_W),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_data   (ch_data),
      .chose     (chose),
      .scan_en   (scan_en),
      .freeze    (freeze),
      .mon_data  (mon_data),
      .mon_ch    (mon_ch),
      .mon_valid (mon_valid),
      .changed   (changed)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   localparam int MD_MAN = 0, MD_SCAN = 1, MD_HOLD = 2;
   int                mode;
   int                scan_t;          // cycles spent in scan since entry
   logic              prev_frz;
   logic [DATA_W-1:0] snap [CH_NUM];
   logic [DATA_W-1:0] exp_data;
   logic [SEL_W-1:0]  exp_ch;
   logic              exp_valid;
   logic              exp_chg;

   always @(posedge clk or posedge rst) begin
      int idx;
      logic [DATA_W-1:0] d;
      logic v;
      if (rst) begin
         mode = MD_MAN; scan_t = 0; prev_frz = 1'b0;
         for (int k = 0; k < CH_NUM; k++) snap[k] = '0;
         exp_data = '0; exp_ch = '0; exp_valid = 1'b0; exp_chg = 1'b0;
      end else begin
         idx = (mode == MD_SCAN) ? (scan_t / SCAN_DIV) % CH_NUM : int'(chose);
         v   = (idx < CH_NUM);
         d   = '0;
         if (v) d = (mode == MD_HOLD) ? snap[idx] : ch_data[idx*DATA_W +: DATA_W];
         exp_chg   = exp_valid && v && (SEL_W'(idx) == exp_ch) && (d != exp_data) && (mode != MD_HOLD);
         exp_data  = d;
         exp_ch    = SEL_W'(idx);
         exp_valid = v;
         if (freeze && !prev_frz) begin
            for (int k = 0; k < CH_NUM; k++) snap[k] = ch_data[k*DATA_W +: DATA_W];
            mode = MD_HOLD;
         end else if (mode == MD_HOLD) begin
            if (!freeze) begin
               if (SCAN_ON && scan_en) begin mode = MD_SCAN; scan_t = 0; end
               else mode = MD_MAN;
            end
         end else if (mode == MD_MAN) begin
            if (SCAN_ON && scan_en) begin mode = MD_SCAN; scan_t = 0; end
         end else begin
            if (!scan_en) mode = MD_MAN;
            else scan_t++;
         end
         prev_frz = freeze;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #4;
      if (!rst) begin
         check("mon_data", 16'(mon_data), 16'(exp_data));
         check("mon_ch", 16'(mon_ch), 16'(exp_ch));
         check("mon_valid", 16'(mon_valid), 16'(exp_valid));
         check("changed", 16'(changed), 16'(exp_chg));
      end
   end

   task automatic tick();
      @(posedge clk);
      #6;
   endtask

   task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
      ch_data[k*DATA_W +: DATA_W] = v;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data"}, 16'(mon_data), 16'h0);
      check({tag, "_ch"}, 16'(mon_ch), 16'h0);
      check({tag, "_valid"}, 16'(mon_valid), 16'h0);
      check({tag, "_chg"}, 16'(changed), 16'h0);
   endtask

   initial begin
      rst = 1'b1; scan_en = 1'b0; freeze = 1'b0; chose = 4'd3;
      for (int k = 0; k < CH_NUM; k++) set_ch(k, 8'(8'h10 + k));
      #1;
      check_zero("rst");
      repeat (2) tick();
      rst = 1'b0;

      // manual select
      tick();
      check("t1_data", 16'(mon_data), 16'h13);
      check("t1_ch", 16'(mon_ch), 16'h3);
      check("t1_valid", 16'(mon_valid), 16'h1);
      check("t1_chg", 16'(changed), 16'h0);

      // change detect
      chose = 4'd5; tick();
      set_ch(5, 8'hA5); tick();
      check("t2_data", 16'(mon_data), 16'hA5);
      check("t2_chg", 16'(changed), 16'h1);
      tick();
      check("t2_chg_once", 16'(changed), 16'h0);
      chose = 4'd6; tick();
      check("t2_sw_data", 16'(mon_data), 16'h16);
      check("t2_sw_chg", 16'(changed), 16'h0);

      // out-of-range index
      chose = 4'd9; tick();
      check("oor_data", 16'(mon_data), 16'h0);
      check("oor_valid", 16'(mon_valid), 16'h0);
      check("oor_ch", 16'(mon_ch), 16'h9);

      // auto-scan
      chose = 4'd3; scan_en = 1'b1; tick();
      for (int i = 1; i <= 33; i++) begin
         tick();
         if (i == 4)  check("scan_i4", 16'(mon_ch), SCAN_ON ? 16'h0 : 16'h3);
         if (i == 5)  check("scan_i5", 16'(mon_ch), SCAN_ON ? 16'h1 : 16'h3);
         if (i == 32) check("scan_i32", 16'(mon_ch), SCAN_ON ? 16'h7 : 16'h3);
         if (i == 33) check("scan_wrap", 16'(mon_ch), SCAN_ON ? 16'h0 : 16'h3);
      end
      scan_en = 1'b0; chose = 4'd2; tick(); tick();
      check("scan_exit", 16'(mon_ch), 16'h2);

      // freeze
      set_ch(2, 8'h22); freeze = 1'b1; tick();
      set_ch(2, 8'hFF); tick(); tick();
      check("hold_data", 16'(mon_data), 16'h22);
      check("hold_chg", 16'(changed), 16'h0);
      freeze = 1'b0; tick(); tick();
      check("unfreeze", 16'(mon_data), 16'hFF);

      // freeze and scan_en together
      chose = 4'd5; freeze = 1'b1; scan_en = 1'b1; tick();
      tick();
      check("hold_win", 16'(mon_data), 16'hA5);
      freeze = 1'b0; tick(); tick();
      check("hold2scan", 16'(mon_ch), SCAN_ON ? 16'h0 : 16'h5);

      // reset mid-scan, freeze held across reset, reset mid-hold
      repeat (5) tick();
      rst = 1'b1; #1;
      check_zero("rst_scan");
      tick();
      freeze = 1'b1; rst = 1'b0; tick(); tick();
      rst = 1'b1; #1;
      check_zero("rst_hold");
      tick();
      rst = 1'b0; freeze = 1'b0; scan_en = 1'b0; tick();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0)
            set_ch($urandom_range(0, CH_NUM - 1), 8'($urandom_range(0, 3)));
         if ($urandom_range(0, 40) == 0) ch_data = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) chose = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) scan_en = ~scan_en;
         if ($urandom_range(0, 29) == 0) freeze = ~freeze;
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
